// File: rtl/inv_rr_scheduler.sv
// inv_rr_scheduler: burst-limited round-robin sharing of one registered-inverter datapath among NREQ requesters.
// Latency: grant at edge E -> dp_in valid in cycle E+1 -> resp_valid/resp_data in cycle E+1+LAT.
// Backpressure: requesters are held off only by arbitration and enable; responses have none and return in issue order.
module inv_rr_scheduler #(
    parameter int WIDTH = 52,
    parameter int NREQ  = 4,
    parameter int LAT   = 2,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      dp_in,
    input  logic [WIDTH-1:0]      dp_out,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  idle,
    output logic [CNT_W-1:0]      issued_cnt
);

    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW   = $clog2(BURST + 1);
    // Slot 0 travels alongside dp_in; the remaining LAT slots cover the datapath itself.
    localparam int TAGS = LAT + 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    tag_t           tag_q [TAGS];
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] prev_id_q;
    logic           prev_vld_q;
    logic [BW-1:0]  burst_q;

    logic [WIDTH-1:0] req_word [NREQ];
    logic             win_vld;
    logic [IDW-1:0]   win_id;
    logic             hs_vld;
    logic [BW-1:0]    burst_nxt;
    logic [IDW-1:0]   win_inc;
    logic             burst_hit;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the farthest position back to the pointer so the nearest valid requester is the last writer.
    always_comb begin : arb
        logic [IDW-1:0] idx;
        idx     = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    assign hs_vld    = enable & win_vld;
    assign req_ready = hs_vld ? (NREQ'(1) << win_id) : '0;

    always_comb begin
        burst_nxt = (prev_vld_q && (prev_id_q == win_id)) ? (burst_q + BW'(1)) : BW'(1);
        win_inc   = (win_id == IDW'(NREQ - 1)) ? '0 : (win_id + IDW'(1));
        burst_hit = (burst_nxt == BW'(BURST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < TAGS; s++) begin
                tag_q[s] <= '0;
            end
            ptr_q      <= '0;
            prev_id_q  <= '0;
            prev_vld_q <= 1'b0;
            burst_q    <= '0;
            dp_in      <= '0;
            issued_cnt <= '0;
        end else begin
            tag_q[0].vld <= hs_vld;
            tag_q[0].id  <= win_id;
            for (int s = 1; s < TAGS; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            if (hs_vld) begin
                dp_in      <= req_word[win_id];
                prev_id_q  <= win_id;
                prev_vld_q <= 1'b1;
                if (burst_hit) begin
                    ptr_q   <= win_inc;
                    burst_q <= '0;
                end else begin
                    ptr_q   <= win_id;
                    burst_q <= burst_nxt;
                end
                if (issued_cnt != '1) begin
                    issued_cnt <= issued_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign resp_valid = tag_q[TAGS-1].vld ? (NREQ'(1) << tag_q[TAGS-1].id) : '0;
    assign resp_data  = dp_out;

    always_comb begin
        idle = 1'b1;
        for (int s = 0; s < TAGS; s++) begin
            if (tag_q[s].vld) begin
                idle = 1'b0;
            end
        end
    end

endmodule
